mult_matrix_skew: RTL and testbench

MULT_MATRIX_SKEW -- requirements
Module: mult_matrix_skew

---
 rtl/mult_matrix_skew.sv | 138 +++++++++++++
 tb/tb_mult_matrix_skew.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_matrix_skew.sv
// Skews an aligned vector stream into a systolic-array feed: lane i is delayed by i cycles.
// Optional MATRIX_SKEW_ZERO_FILL_EN makes lane data 0 wherever the lane is not valid.
module mult_matrix_skew #(
  parameter int unsigned data_size = 4,
  parameter int unsigned size      = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [data_size*size-1:0] input_stream,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [data_size*size-1:0] output_stream,
  output logic [size-1:0]           lane_valid,
  output logic                      out_valid,
  output logic                      out_last,
  output logic                      busy
);

  localparam int unsigned CNT_W = (size > 1) ? $clog2(size) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(size - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic [size-1:0]  last_q, last_d;

  // Burst control: DRAIN holds off input until the last vector has left every lane.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_ready = (state_q != DRAIN);
    busy     = (state_q != IDLE);
    accept   = in_valid && in_ready;
    case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          if (in_last) begin
            if (size > 1) begin
              state_d = DRAIN;
              cnt_d   = CNT_LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = STREAM;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Last flag rides alongside the longest lane.
  if (size == 1) begin : g_last_one
    always_comb last_d = accept && in_last;
  end else begin : g_last_many
    always_comb last_d = {last_q[size-2:0], accept && in_last};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end

  assign out_last = last_q[size-1];

  for (genvar i = 0; i < size; i++) begin : g_lane
    logic [data_size-1:0]         stage0;
    logic [(i+1)*data_size-1:0]   data_q, data_d;
    logic [i:0]                   vld_q, vld_d;

    always_comb begin
      stage0 = input_stream[(size-i)*data_size-1 -: data_size];
`ifdef MATRIX_SKEW_ZERO_FILL_EN
      if (!accept) begin
        stage0 = '0;
      end
`endif
    end

    if (i == 0) begin : g_first
      always_comb begin
        data_d = stage0;
        vld_d  = accept;
      end
    end else begin : g_rest
      always_comb begin
        data_d = {data_q[i*data_size-1:0], stage0};
        vld_d  = {vld_q[i-1:0], accept};
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q <= '0;
        vld_q  <= '0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
      end
    end

    assign output_stream[(size-i)*data_size-1 -: data_size] = data_q[(i+1)*data_size-1 -: data_size];
    assign lane_valid[i] = vld_q[i];
  end

  assign out_valid = |lane_valid;

endmodule

// File: tb/tb_mult_matrix_skew.sv
// Scoreboard bench for mult_matrix_skew: size=3 instance plus a size=1 instance.
module tb_mult_matrix_skew;

  localparam int unsigned DS = 4;
  localparam int unsigned SZ = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [DS*SZ-1:0] input_stream;
  logic            in_valid, in_last;
  logic            in_ready;
  logic [DS*SZ-1:0] output_stream;
  logic [SZ-1:0]   lane_valid;
  logic            out_valid, out_last, busy;

  logic [DS-1:0]   in1_stream;
  logic            in1_valid, in1_last;
  logic            in1_ready;
  logic [DS-1:0]   out1_stream;
  logic [0:0]      lane1_valid;
  logic            out1_valid, out1_last, busy1;

  always #5 clk = ~clk;

  mult_matrix_skew #(.data_size(DS), .size(SZ)) dut (
    .clk(clk), .reset(reset), .input_stream(input_stream), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .output_stream(output_stream),
    .lane_valid(lane_valid), .out_valid(out_valid), .out_last(out_last), .busy(busy)
  );

  mult_matrix_skew #(.data_size(DS), .size(1)) dut1 (
    .clk(clk), .reset(reset), .input_stream(in1_stream), .in_valid(in1_valid),
    .in_last(in1_last), .in_ready(in1_ready), .output_stream(out1_stream),
    .lane_valid(lane1_valid), .out_valid(out1_valid), .out_last(out1_last), .busy(busy1)
  );

  typedef struct {
    int          due;
    int          lane;
    logic [DS-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   mst      = 0;
  int   drain_left = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs, model the accept, then compare outputs after the edge.
  task automatic drive(input logic v, input logic l, input logic [DS*SZ-1:0] d);
    logic          acc;
    logic [SZ-1:0] elv;
    logic [DS-1:0] ed [SZ];
    logic          el;
    in_valid     = v;
    in_last      = l;
    input_stream = d;
    check_eq("in_ready_pre", 32'(in_ready), 32'(mst != 2));
    acc = v && (mst != 2);
    if (acc) begin
      for (int i = 0; i < SZ; i++) begin
        sb.push_back('{due: cyc + i, lane: i, data: d[(SZ-i)*DS-1 -: DS]});
      end
      if (l) sb.push_back('{due: cyc + SZ - 1, lane: -1, data: '0});
    end
    if (mst == 2) begin
      drain_left--;
      if (drain_left == 0) mst = 0;
    end else if (acc) begin
      if (l) begin
        mst = 2;
        drain_left = SZ - 1;
      end else begin
        mst = 1;
      end
    end
    @(posedge clk);
    #1;
    elv = '0;
    el  = 1'b0;
    for (int i = 0; i < SZ; i++) ed[i] = '0;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].due == cyc) begin
        if (sb[k].lane < 0) el = 1'b1;
        else begin
          elv[sb[k].lane] = 1'b1;
          ed[sb[k].lane]  = sb[k].data;
        end
        sb.delete(k);
      end
    end
    check_eq("lane_valid", 32'(lane_valid), 32'(elv));
    check_eq("out_valid", 32'(out_valid), 32'(elv != '0));
    check_eq("out_last", 32'(out_last), 32'(el));
    check_eq("busy", 32'(busy), 32'(mst != 0));
    check_eq("in_ready", 32'(in_ready), 32'(mst != 2));
    for (int i = 0; i < SZ; i++) begin
      if (elv[i]) begin
        check_eq($sformatf("lane%0d_data", i), 32'(output_stream[(SZ-i)*DS-1 -: DS]), 32'(ed[i]));
      end
`ifdef MATRIX_SKEW_ZERO_FILL_EN
      else begin
        check_eq($sformatf("lane%0d_zero", i), 32'(output_stream[(SZ-i)*DS-1 -: DS]), 32'h0);
      end
`endif
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(1'b0, 1'b0, '0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_output_stream", 32'(output_stream), 32'h0);
    check_eq("rst_lane_valid", 32'(lane_valid), 32'h0);
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_out_last", 32'(out_last), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_in_ready", 32'(in_ready), 32'h1);
    check_eq("rst1_output_stream", 32'(out1_stream), 32'h0);
    check_eq("rst1_in_ready", 32'(in1_ready), 32'h1);
  endtask

  initial begin
    reset        = 1'b1;
    input_stream = '0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    in1_stream   = '0;
    in1_valid    = 1'b0;
    in1_last     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    // Single vector with last
    drive(1'b1, 1'b1, 12'hABC);
    idle(4);

    // Back-to-back burst
    drive(1'b1, 1'b0, 12'h123);
    drive(1'b1, 1'b0, 12'h456);
    drive(1'b1, 1'b1, 12'h789);
    check_eq("burst_vector", 32'(output_stream), 32'h753);
    idle(4);

    // Bubble between two vectors
    drive(1'b1, 1'b0, 12'h111);
    drive(1'b0, 1'b0, 12'h000);
    drive(1'b1, 1'b1, 12'h222);
    idle(4);

    // in_last without in_valid is ignored
    drive(1'b0, 1'b1, 12'hFFF);
    idle(2);

    // Valid held through DRAIN; new burst lands as ready returns
    drive(1'b1, 1'b1, 12'h3C5);
    drive(1'b1, 1'b0, 12'hE7D);
    drive(1'b1, 1'b0, 12'hE7D);
    drive(1'b1, 1'b1, 12'h6A9);
    idle(4);

    // Random traffic
    for (int r = 0; r < 40; r++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 12'($urandom));
    end
    idle(5);

    // Reset between edges during DRAIN discards the burst
    drive(1'b1, 1'b0, 12'h9A5);
    drive(1'b1, 1'b1, 12'h5A9);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    sb.delete();
    mst = 0;
    drain_left = 0;
    #2;
    reset = 1'b0;
    drive(1'b1, 1'b1, 12'hABC);
    idle(4);
    check_eq("sb_empty", 32'(sb.size()), 32'h0);

    // Single-lane instance
    in1_valid = 1'b1; in1_last = 1'b1; in1_stream = 4'h5;
    #1;
    check_eq("s1_ready_pre", 32'(in1_ready), 32'h1);
    @(posedge clk); #1;
    check_eq("s1_data", 32'(out1_stream), 32'h5);
    check_eq("s1_valid", 32'(lane1_valid), 32'h1);
    check_eq("s1_last", 32'(out1_last), 32'h1);
    check_eq("s1_ready", 32'(in1_ready), 32'h1);
    check_eq("s1_busy", 32'(busy1), 32'h0);
    in1_valid = 1'b1; in1_last = 1'b0; in1_stream = 4'h3;
    @(posedge clk); #1;
    check_eq("s1_data2", 32'(out1_stream), 32'h3);
    check_eq("s1_last2", 32'(out1_last), 32'h0);
    check_eq("s1_busy2", 32'(busy1), 32'h1);
    in1_valid = 1'b0; in1_last = 1'b0;
    @(posedge clk); #1;
    check_eq("s1_valid3", 32'(out1_valid), 32'h0);
    check_eq("s1_ready3", 32'(in1_ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
